// File: rtl/matrix_dsp_scheduler.sv
// matrix_dsp_scheduler: round-robin sharing of one MatrixDSP among NUM_REQ
// transform clients, with a discarded prime run when the loaded program differs.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req                 per-client job request (level, held until req_grant)
//   req_program         per-client 8-bit program start index
//   req_vector          per-client 128-bit input vector
//   req_matrix_sel      per-client 2-bit matrix bank index
//   req_grant           one-hot 1-cycle pulse when a job is latched
//   rsp_valid           one-hot 1-cycle pulse when rsp_data is valid
//   rsp_data            128-bit result, held until the next rsp_valid
//   busy                high whenever the FSM is not IDLE
//   dsp_cycle           MatrixDSP cycle strobe
//   dsp_ready           MatrixDSP ready
//   dsp_next_program    MatrixDSP nextProgramPosition (registered)
//   dsp_vector          MatrixDSP inputVector (registered)
//   matrix_bank_sel     matrix row store bank select (registered)
//   dsp_result          MatrixDSP outputVector
//   timeout_err         sticky watchdog flag (MATRIX_DSP_SCHED_TIMEOUT_EN only)
//
// Optional feature macro: MATRIX_DSP_SCHED_TIMEOUT_EN adds a watchdog on the
// PRIME_WAIT/WAIT states and the timeout_err output.

module matrix_dsp_scheduler #(
    parameter int          NUM_REQ        = 4,
    parameter logic [7:0]  PROGRAM_RESET  = 8'd0,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_program,
    input  logic [128*NUM_REQ-1:0] req_vector,
    input  logic [2*NUM_REQ-1:0]   req_matrix_sel,
    output logic [NUM_REQ-1:0]     req_grant,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [127:0]           rsp_data,
    output logic                   busy,
    output logic                   dsp_cycle,
    input  logic                   dsp_ready,
    output logic [7:0]             dsp_next_program,
    output logic [127:0]           dsp_vector,
    output logic [1:0]             matrix_bank_sel,
    input  logic [127:0]           dsp_result
`ifdef MATRIX_DSP_SCHED_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        PRIME_WAIT,
        LAUNCH,
        WAIT
    } state_t;

    state_t state, nextState;

    logic [IW-1:0]      rrPtr;
    logic [7:0]         loadedProg;

    logic               winValid;
    logic [IW-1:0]      winIdx;
    logic [7:0]         winProg;
    logic [127:0]       winVec;
    logic [1:0]         winSel;
    logic [NUM_REQ-1:0] winOneHot;
    logic [NUM_REQ-1:0] rrOneHot;

    logic               doGrant;
    logic               primeDone;
    logic               runDone;
    logic               wdHit;

    int                 cand;

    // Round-robin search starting just above the last winner.
    always_comb begin
        winValid = 1'b0;
        winIdx   = '0;
        winProg  = '0;
        winVec   = '0;
        winSel   = '0;
        cand     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rrPtr) + k) % NUM_REQ;
            if (!winValid && req[cand]) begin
                winValid = 1'b1;
                winIdx   = IW'(cand);
                winProg  = req_program[cand*8 +: 8];
                winVec   = req_vector[cand*128 +: 128];
                winSel   = req_matrix_sel[cand*2 +: 2];
            end
        end
    end

    assign winOneHot = NUM_REQ'(1) << winIdx;
    assign rrOneHot  = NUM_REQ'(1) << rrPtr;

    assign busy      = (state != IDLE);
    assign dsp_cycle = (state == PRIME) || (state == LAUNCH);

`ifdef MATRIX_DSP_SCHED_TIMEOUT_EN
    localparam logic [15:0] WdLimit = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wdCnt;

    // A real completion on the limit cycle wins over the watchdog.
    assign wdHit = ((state == PRIME_WAIT) || (state == WAIT))
                   && !dsp_ready && (wdCnt == WdLimit);
`else
    assign wdHit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        doGrant   = 1'b0;
        primeDone = 1'b0;
        runDone   = 1'b0;
        unique case (state)
            IDLE: begin
                if (winValid && dsp_ready) begin
                    doGrant   = 1'b1;
                    nextState = (winProg == loadedProg) ? LAUNCH : PRIME;
                end
            end
            PRIME: begin
                nextState = PRIME_WAIT;
            end
            PRIME_WAIT: begin
                if (dsp_ready) begin
                    primeDone = 1'b1;
                    nextState = LAUNCH;
                end
            end
            LAUNCH: begin
                nextState = WAIT;
            end
            WAIT: begin
                if (dsp_ready) begin
                    runDone   = 1'b1;
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        if (wdHit) begin
            nextState = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rrPtr            <= IW'(NUM_REQ - 1);
            loadedProg       <= PROGRAM_RESET;
            dsp_next_program <= PROGRAM_RESET;
            dsp_vector       <= '0;
            matrix_bank_sel  <= '0;
            rsp_data         <= '0;
            rsp_valid        <= '0;
            req_grant        <= '0;
        end else begin
            req_grant <= '0;
            rsp_valid <= '0;
            if (doGrant) begin
                rrPtr            <= winIdx;
                dsp_next_program <= winProg;
                dsp_vector       <= winVec;
                matrix_bank_sel  <= winSel;
                req_grant        <= winOneHot;
            end
            // The DSP reloads its program counter at the end of every run.
            if (primeDone) begin
                loadedProg <= dsp_next_program;
            end
            if (runDone) begin
                rsp_data   <= dsp_result;
                rsp_valid  <= rrOneHot;
                loadedProg <= dsp_next_program;
            end
            if (wdHit) begin
                rsp_data   <= '0;
                rsp_valid  <= rrOneHot;
                // Program state of a hung DSP is unknown: force a prime.
                loadedProg <= 8'hFF;
            end
        end
    end

`ifdef MATRIX_DSP_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdCnt       <= '0;
            timeout_err <= 1'b0;
        end else begin
            // PRIME and LAUNCH always precede the wait states.
            if ((state == PRIME) || (state == LAUNCH)) begin
                wdCnt <= '0;
            end else if ((state == PRIME_WAIT) || (state == WAIT)) begin
                wdCnt <= wdCnt + 16'd1;
            end
            if (wdHit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_matrix_dsp_scheduler.sv
// tb_matrix_dsp_scheduler: table-driven jobs plus rotation, drop, reset and
// watchdog sequences against a behavioural MatrixDSP and a result scoreboard.

module tb_matrix_dsp_scheduler;

    localparam int NR  = 4;
    localparam int RUN = 5;

    logic           clk;
    logic           reset;
    logic [NR-1:0]  req;
    logic [8*NR-1:0]   reqProgram;
    logic [128*NR-1:0] reqVector;
    logic [2*NR-1:0]   reqMatrixSel;
    logic [NR-1:0]  reqGrant;
    logic [NR-1:0]  rspValid;
    logic [127:0]   rspData;
    logic           busy;
    logic           dspCycle;
    logic           dspReady;
    logic [7:0]     dspNextProgram;
    logic [127:0]   dspVector;
    logic [1:0]     matrixBankSel;
    logic [127:0]   dspResult;
`ifdef MATRIX_DSP_SCHED_TIMEOUT_EN
    logic           timeoutErr;
`endif

    matrix_dsp_scheduler #(
        .NUM_REQ(NR),
        .PROGRAM_RESET(8'd0),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_program(reqProgram),
        .req_vector(reqVector),
        .req_matrix_sel(reqMatrixSel),
        .req_grant(reqGrant),
        .rsp_valid(rspValid),
        .rsp_data(rspData),
        .busy(busy),
        .dsp_cycle(dspCycle),
        .dsp_ready(dspReady),
        .dsp_next_program(dspNextProgram),
        .dsp_vector(dspVector),
        .matrix_bank_sel(matrixBankSel),
        .dsp_result(dspResult)
`ifdef MATRIX_DSP_SCHED_TIMEOUT_EN
        ,
        .timeout_err(timeoutErr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] model(logic [127:0] v, logic [1:0] b,
                                           logic [7:0] p);
        return {v[119:0], v[127:120]} ^ {16{p}} ^ {64{b}};
    endfunction

    // Behavioural MatrixDSP: program counter is loaded at the end of a run.
    logic         stall;
    int           dspCnt;
    logic [7:0]   dspLoaded;
    logic [127:0] latVec;
    logic [1:0]   latBank;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dspReady  <= 1'b1;
            dspCnt    <= 0;
            dspLoaded <= 8'h00;
            dspResult <= '0;
            latVec    <= '0;
            latBank   <= '0;
        end else if (dspReady) begin
            if (dspCycle) begin
                dspReady <= 1'b0;
                dspCnt   <= RUN;
                latVec   <= dspVector;
                latBank  <= matrixBankSel;
            end
        end else if (!stall) begin
            if (dspCnt > 1) begin
                dspCnt <= dspCnt - 1;
            end else begin
                dspReady  <= 1'b1;
                dspResult <= model(latVec, latBank, dspLoaded);
                dspLoaded <= dspNextProgram;
            end
        end
    end

    typedef struct {
        int           client;
        logic [7:0]   prog;
        logic [127:0] vec;
        logic [1:0]   bank;
        int           pulses;
    } vec_t;

    typedef struct {
        logic [NR-1:0] who;
        logic [127:0]  data;
    } exp_t;

    exp_t          sbQ[$];
    logic [NR-1:0] grantLog[$];
    vec_t          tbl[6];

    int         nVec;
    int         nMis;
    int         cycCount;
    int         rspCount;
    logic [7:0] curProg;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (dspCycle) begin
            cycCount++;
            check("cycle_busy", 128'(busy), 128'(1));
            check("cycle_prog", 128'(dspNextProgram), 128'(curProg));
        end
        if (reqGrant != '0) begin
            grantLog.push_back(reqGrant);
        end
        if (rspValid != '0) begin
            rspCount++;
            if (sbQ.size() == 0) begin
                nVec++;
                nMis++;
                $display("FAIL rsp_unexpected: got %h, want none", rspValid);
            end else begin
                e = sbQ.pop_front();
                check("rsp_who", 128'(rspValid), 128'(e.who));
                check("rsp_data", rspData, e.data);
            end
        end
    endtask

    task automatic waitGrant();
        int n0;
        int t;
        n0 = grantLog.size();
        t  = 0;
        while (grantLog.size() == n0 && t < 60) begin
            tick();
            t++;
        end
        if (grantLog.size() == n0) begin
            nVec++;
            nMis++;
            $display("FAIL grant_timeout: got none, want a grant");
        end
    endtask

    task automatic waitRsp(int target);
        int t;
        t = 0;
        while (rspCount < target && t < 300) begin
            tick();
            t++;
        end
        if (rspCount < target) begin
            nVec++;
            nMis++;
            $display("FAIL rsp_timeout: got %0d, want %0d", rspCount, target);
        end
    endtask

    task automatic setClient(int c, logic [7:0] p, logic [127:0] v,
                             logic [1:0] b);
        reqProgram[c*8 +: 8]     = p;
        reqVector[c*128 +: 128]  = v;
        reqMatrixSel[c*2 +: 2]   = b;
    endtask

    task automatic runJob(vec_t j);
        int c0;
        int r0;
        int g0;
        logic [NR-1:0] oh;
        oh = NR'(1) << j.client;
        setClient(j.client, j.prog, j.vec, j.bank);
        curProg = j.prog;
        sbQ.push_back('{oh, model(j.vec, j.bank, j.prog)});
        c0 = cycCount;
        r0 = rspCount;
        g0 = grantLog.size();
        req[j.client] = 1'b1;
        waitGrant();
        req[j.client] = 1'b0;
        // Scramble the client inputs: the job must already be latched.
        setClient(j.client, 8'hEE, ~j.vec, ~j.bank);
        if (grantLog.size() > g0) begin
            check("grant", 128'(grantLog[g0]), 128'(oh));
        end
        waitRsp(r0 + 1);
        check("pulses", 128'(cycCount - c0), 128'(j.pulses));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int r0;
        int g0;
        logic [NR-1:0] order[5];

        nVec = 0;
        nMis = 0;
        cycCount = 0;
        rspCount = 0;
        curProg = 8'h00;
        stall = 1'b0;
        reset = 1'b1;
        req = '0;
        reqProgram = '0;
        reqVector = '0;
        reqMatrixSel = '0;

        tbl[0] = '{0, 8'h00, {4{32'h1234_5678}}, 2'd1, 1};
        tbl[1] = '{1, 8'h20, {4{32'hDEAD_BEEF}}, 2'd2, 2};
        tbl[2] = '{2, 8'h20, {4{32'h0F0F_3C3C}}, 2'd3, 1};
        tbl[3] = '{3, 8'h05, {4{32'hA5A5_0001}}, 2'd0, 2};
        tbl[4] = '{0, 8'h05, {4{32'h8000_0042}}, 2'd2, 1};
        tbl[5] = '{3, 8'h00, {4{32'h7777_1111}}, 2'd1, 2};

        repeat (3) tick();
        check("rst_grant", 128'(reqGrant), 128'(0));
        check("rst_rsp_valid", 128'(rspValid), 128'(0));
        check("rst_rsp_data", rspData, 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_cycle", 128'(dspCycle), 128'(0));
        check("rst_next_prog", 128'(dspNextProgram), 128'(0));
        check("rst_vector", dspVector, 128'(0));
        check("rst_bank", 128'(matrixBankSel), 128'(0));
`ifdef MATRIX_DSP_SCHED_TIMEOUT_EN
        check("rst_timeout_err", 128'(timeoutErr), 128'(0));
`endif
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 6; i++) begin
            runJob(tbl[i]);
            tick();
        end

        // All clients requesting: strict rotation starting after client 3.
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b0100;
        order[3] = 4'b1000;
        order[4] = 4'b0001;
        curProg = 8'h20;
        for (int c = 0; c < NR; c++) begin
            setClient(c, 8'h20, {4{32'h0100_0000 + 32'(c)}}, 2'(c));
        end
        for (int k = 0; k < 5; k++) begin
            sbQ.push_back('{order[k],
                model({4{32'h0100_0000 + 32'($clog2(int'(order[k])))}},
                      2'($clog2(int'(order[k]))), 8'h20)});
        end
        c0 = cycCount;
        r0 = rspCount;
        g0 = grantLog.size();
        req = 4'b1111;
        for (int t = 0; t < 300 && grantLog.size() < g0 + 5; t++) begin
            tick();
        end
        req = '0;
        waitRsp(r0 + 5);
        for (int k = 0; k < 5; k++) begin
            if (grantLog.size() > g0 + k) begin
                check("rot_grant", 128'(grantLog[g0 + k]), 128'(order[k]));
            end else begin
                nVec++;
                nMis++;
                $display("FAIL rot_grant: got none, want %b", order[k]);
            end
        end
        check("rot_pulses", 128'(cycCount - c0), 128'(6));
        tick();

        // Client 2 drops its request while client 1 is being served.
        r0 = rspCount;
        g0 = grantLog.size();
        setClient(1, 8'h20, {4{32'h5555_AAAA}}, 2'd1);
        sbQ.push_back('{4'b0010, model({4{32'h5555_AAAA}}, 2'd1, 8'h20)});
        req[1] = 1'b1;
        waitGrant();
        req[1] = 1'b0;
        setClient(2, 8'h20, {4{32'h2222_2222}}, 2'd2);
        setClient(3, 8'h20, {4{32'h3333_3333}}, 2'd3);
        sbQ.push_back('{4'b1000, model({4{32'h3333_3333}}, 2'd3, 8'h20)});
        req[2] = 1'b1;
        req[3] = 1'b1;
        repeat (2) tick();
        req[2] = 1'b0;
        waitGrant();
        req[3] = 1'b0;
        waitRsp(r0 + 2);
        repeat (4) tick();
        check("drop_grant_cnt", 128'(grantLog.size() - g0), 128'(2));
        if (grantLog.size() > g0 + 1) begin
            check("drop_grant1", 128'(grantLog[g0 + 1]), 128'(4'b1000));
        end

        // Reset while the DSP is running: no response may escape.
        setClient(0, 8'h20, {4{32'h0BAD_F00D}}, 2'd2);
        curProg = 8'h20;
        req[0] = 1'b1;
        waitGrant();
        req[0] = 1'b0;
        repeat (3) tick();
        check("pre_rst_busy", 128'(busy), 128'(1));
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 128'(rspValid), 128'(0));
        check("mid_rst_rsp_data", rspData, 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_grant", 128'(reqGrant), 128'(0));
        check("mid_rst_next_prog", 128'(dspNextProgram), 128'(0));
        check("mid_rst_vector", dspVector, 128'(0));
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        runJob('{2, 8'h20, {4{32'hCAFE_0123}}, 2'd1, 2});
        tick();

`ifdef MATRIX_DSP_SCHED_TIMEOUT_EN
        // DSP hangs after launch: watchdog returns a zero result.
        stall = 1'b1;
        r0 = rspCount;
        setClient(1, 8'h20, {4{32'h9999_0000}}, 2'd0);
        sbQ.push_back('{4'b0010, 128'(0)});
        req[1] = 1'b1;
        waitGrant();
        req[1] = 1'b0;
        waitRsp(r0 + 1);
        tick();
        check("to_err", 128'(timeoutErr), 128'(1));
        check("to_busy", 128'(busy), 128'(0));
        stall = 1'b0;
        repeat (10) tick();
        runJob('{0, 8'h20, {4{32'h1357_9BDF}}, 2'd3, 2});
        check("to_err_sticky", 128'(timeoutErr), 128'(1));
`endif

        repeat (3) tick();
        check("sb_empty", 128'(sbQ.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/matrix_dsp_scheduler.md
Name: matrix_dsp_scheduler

Overview:
Round-robin scheduler that shares one MatrixDSP instance between NUM_REQ transform clients, for example the position, normal and texgen paths.
- Owns the DSP handshake: cycle/ready pulse and nextProgramPosition lookahead.
- Latches each granted job's vector and matrix-bank select.
- Returns the DSP result to the winning client.
- The DSP loads its program counter at the end of each run, not at launch. When the loaded program differs from the one a job needs, the scheduler inserts a discarded "prime" run first.

Parameters:
NUM_REQ, 4, number of clients (2..8)
PROGRAM_RESET, 0, program index driven on dsp_next_program out of reset; equals the program the DSP holds after its reset prime
TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-client job request, level; held until the matching req_grant
req_program  in  8*NUM_REQ  per-client program start index (client i at [8i+7:8i])
req_vector  in  128*NUM_REQ  per-client input vector
req_matrix_sel  in  2*NUM_REQ  per-client matrix bank index
req_grant  out  NUM_REQ  one-hot, 1-cycle pulse when a job is accepted and latched
rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse when rsp_data is valid for that client
rsp_data  out  128  result vector, held until the next rsp_valid
busy  out  1  high in any state other than IDLE
dsp_cycle  out  1  to MatrixDSP cycle
dsp_ready  in  1  from MatrixDSP ready
dsp_next_program  out  8  to MatrixDSP nextProgramPosition (registered)
dsp_vector  out  128  to MatrixDSP inputVector (registered)
matrix_bank_sel  out  2  to matrix row store; selects the rows fed to MatrixDSP (registered)
dsp_result  in  128  from MatrixDSP outputVector

Behaviour:
Reset values (asynchronous, active-high): all outputs 0, except dsp_next_program = PROGRAM_RESET. Internal registers: loaded_prog = PROGRAM_RESET, rr_ptr = NUM_REQ-1, state = IDLE.

IDLE:
- Arbitrate when any req bit is set and dsp_ready = 1.
- Winner is the first set bit searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
- On the next edge: latch the winner's program/vector/matrix_sel into job registers, pulse req_grant[winner], set rr_ptr = winner.
- Drive dsp_vector/matrix_bank_sel from the job registers; dsp_next_program = job program.
- If job program == loaded_prog go to LAUNCH, else go to PRIME.

PRIME:
- Assert dsp_cycle for 1 cycle, then go to PRIME_WAIT.

PRIME_WAIT:
- On the first cycle with dsp_ready = 1: loaded_prog <= dsp_next_program, discard dsp_result, go to LAUNCH.

LAUNCH:
- Assert dsp_cycle for 1 cycle; dsp_ready is guaranteed high here. Go to WAIT.

WAIT:
- On the first cycle with dsp_ready = 1 (DSP exit cycle): rsp_data <= dsp_result, pulse rsp_valid[rr_ptr], loaded_prog <= dsp_next_program, go to IDLE.
- dsp_next_program stays at the job program, so a repeat of the same program needs no prime.

Stability and timing:
- dsp_vector, matrix_bank_sel and dsp_next_program are stable from grant until return to IDLE.
- The client may change its req_* inputs after req_grant.
- dsp_cycle is never asserted outside PRIME/LAUNCH.
- Minimum grant-to-rsp_valid latency is DSP run length + 2 cycles; add one DSP run plus 1 cycle when a prime run occurs.
- Back-to-back jobs: arbitration resumes the cycle after rsp_valid.

Boundary cases:
- A client dropping req before grant is legal; it is simply not selected.
- A client requesting again on the cycle of its own rsp_valid is eligible.
- All NUM_REQ requesting continuously are served in strict rotation with no starvation.
- Reset mid-run returns the block to IDLE and suppresses rsp_valid; the DSP's own reset primes it back to PROGRAM_RESET.

Optional Feature:
MATRIX_DSP_SCHED_TIMEOUT_EN
- Defined: adds a 16-bit watchdog counter, cleared on entry to PRIME_WAIT/WAIT and incremented each cycle in those states. Reaching TIMEOUT_CYCLES:
  - forces IDLE;
  - pulses rsp_valid[rr_ptr] with rsp_data = 0;
  - sets output timeout_err (1 bit, sticky, cleared only by reset);
  - sets loaded_prog = 8'hFF so the next job always primes.
- Undefined: no counter and no timeout_err port; waits are unbounded.

Test Plan:
1. Reset, then client 0 requests program 0 with vector V -> req_grant=0001 and no prime run; one dsp_cycle pulse; rsp_valid=0001 with rsp_data = model(V, bank).
2. Client 1 requests program 0x20 while loaded_prog = 0 -> two dsp_cycle pulses (prime, then real); a single rsp_valid=0010; dsp_next_program = 0x20 throughout both runs.
3. req=1111 held continuously, all program 0x20 -> grants 0001, 0010, 0100, 1000, 0001 in order; no prime runs after the first job.
4. Client 2 requests, drops req before it is granted -> no grant to client 2; the other clients' rotation is unaffected.
5. Assert reset during WAIT -> all outputs 0 at once, no rsp_valid, dsp_next_program = PROGRAM_RESET; the next job completes normally.
6. With MATRIX_DSP_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, dsp_ready held low after launch -> at cycle 16 rsp_valid pulses with rsp_data = 0, timeout_err = 1, state returns to IDLE.
